// File: rtl/apb_mvm_engine.sv
// APB slave computing Y = A*X for a runtime-sized signed n x n matrix (n <= DIM), one MAC per cycle.
// Job latency n*n cycles after start; A_IN/X_IN/RESULT accesses wait-state during RUN, other registers never stall.
module apb_mvm_engine #(
    parameter int APB_ADDR_WIDTH = 13,
    parameter int DATA_W         = 8,
    parameter int DIM            = 8,
    parameter int ACC_W          = 2*DATA_W + $clog2(DIM)
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      irq
);
    localparam int SZ_W  = $clog2(DIM + 1);
    localparam int CNT_W = $clog2(DIM*DIM + 1);
    localparam int K_W   = $clog2(DIM*DIM);
    localparam int IDX_W = $clog2(DIM);

    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CTRL   = APB_ADDR_WIDTH'(0);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_SIZE   = APB_ADDR_WIDTH'(1);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_A_IN   = APB_ADDR_WIDTH'(2);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_X_IN   = APB_ADDR_WIDTH'(3);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_STATUS = APB_ADDR_WIDTH'(4);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  a_mem [DIM*DIM];
    logic signed [DATA_W-1:0]  x_mem [DIM];
    logic signed [ACC_W-1:0]   y_q   [DIM];
    logic signed [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]          a_cnt_q;
    logic [SZ_W-1:0]           x_cnt_q;
    logic [SZ_W-1:0]           size_q;
    logic [K_W-1:0]            k_q;
    logic [IDX_W-1:0]          row_q, col_q;
    logic                      ie_q, err_q;

    logic sel_ctrl, sel_size, sel_a, sel_x, sel_status, sel_res;
    logic [7:0] res_idx;
    logic busy, done, acc_ok, wr, rd;
    logic [CNT_W-1:0] nn;
    logic a_full, x_full;
    logic start_req, clr_req, start_ok;
    logic err_a, err_x, err_start, err_size, slv_err, a_ok, x_ok;
    logic last_col, last_mac, res_hit;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_next, y_sel;
    logic signed [31:0]         y_ext;

    assign sel_ctrl   = (PADDR == ADDR_CTRL);
    assign sel_size   = (PADDR == ADDR_SIZE);
    assign sel_a      = (PADDR == ADDR_A_IN);
    assign sel_x      = (PADDR == ADDR_X_IN);
    assign sel_status = (PADDR == ADDR_STATUS);
    assign sel_res    = (PADDR[APB_ADDR_WIDTH-1:8] == (APB_ADDR_WIDTH-8)'(1));
    assign res_idx    = PADDR[7:0];

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign PREADY = !(busy && PSEL && (sel_a || sel_x || sel_res));
    assign acc_ok = PSEL && PENABLE && PREADY;
    assign wr     = acc_ok && PWRITE;
    assign rd     = acc_ok && !PWRITE;

    assign nn     = CNT_W'(size_q) * CNT_W'(size_q);
    assign a_full = (a_cnt_q == nn);
    assign x_full = (x_cnt_q == size_q);

    // Soft clear dominates, so a start bit alongside it is neither a start nor an error.
    assign clr_req   = wr && sel_ctrl && PWDATA[1];
    assign start_req = wr && sel_ctrl && PWDATA[0] && !PWDATA[1];
    assign err_start = start_req && !(a_full && x_full);
    assign start_ok  = start_req && a_full && x_full;
    assign err_a     = wr && sel_a && (a_cnt_q >= nn);
    assign err_x     = wr && sel_x && (x_cnt_q >= size_q);
    assign err_size  = wr && sel_size && ((PWDATA == 32'd0) || (PWDATA > 32'(DIM)) || busy);
    assign slv_err   = err_a || err_x || err_start || err_size;
    assign PSLVERR   = slv_err;
    assign a_ok      = wr && sel_a && !err_a;
    assign x_ok      = wr && sel_x && !err_x;

    assign last_col = (SZ_W'(col_q) == size_q - SZ_W'(1));
    assign last_mac = (CNT_W'(k_q) == nn - CNT_W'(1));
    assign prod     = (2*DATA_W)'(a_mem[k_q]) * (2*DATA_W)'(x_mem[col_q]);
    assign acc_next = ((col_q == '0) ? ACC_W'(0) : acc_q) + ACC_W'(prod);

    assign res_hit = (res_idx < 8'(size_q));
    assign y_sel   = y_q[res_idx[IDX_W-1:0]];
    assign y_ext   = 32'(y_sel);
    assign irq     = done && ie_q;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (last_mac) state_d = DONE;
            DONE: begin
                if (start_ok)          state_d = RUN;
                else if (a_ok || x_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr_req) state_d = IDLE;
    end

    // Operand storage needs no reset: counters gate every read of it.
    always_ff @(posedge HCLK) begin
        if (a_ok) a_mem[a_cnt_q[K_W-1:0]] <= PWDATA[DATA_W-1:0];
        if (x_ok) x_mem[x_cnt_q[IDX_W-1:0]] <= PWDATA[DATA_W-1:0];
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            for (int i = 0; i < DIM; i++) y_q[i] <= '0;
            acc_q   <= '0;
            a_cnt_q <= '0;
            x_cnt_q <= '0;
            size_q  <= SZ_W'(DIM);
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ie_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (clr_req) begin
            for (int i = 0; i < DIM; i++) y_q[i] <= '0;
            a_cnt_q <= '0;
            x_cnt_q <= '0;
            err_q   <= 1'b0;
            ie_q    <= PWDATA[2];
        end else begin
            if (slv_err) err_q <= 1'b1;
            if (wr && sel_ctrl && !err_start) ie_q <= PWDATA[2];
            if (a_ok) a_cnt_q <= a_cnt_q + CNT_W'(1);
            if (x_ok) x_cnt_q <= x_cnt_q + SZ_W'(1);
            if (wr && sel_size && !err_size) size_q <= PWDATA[SZ_W-1:0];
            if (start_ok) begin
                a_cnt_q <= '0;
                x_cnt_q <= '0;
                k_q     <= '0;
                row_q   <= '0;
                col_q   <= '0;
            end
            if (busy) begin
                acc_q <= acc_next;
                k_q   <= k_q + K_W'(1);
                if (last_col) begin
                    y_q[row_q] <= acc_next;
                    col_q      <= '0;
                    row_q      <= row_q + IDX_W'(1);
                end else begin
                    col_q <= col_q + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (rd) begin
            if (sel_ctrl)               PRDATA = {29'd0, ie_q, 2'b00};
            else if (sel_size)          PRDATA = 32'(size_q);
            else if (sel_status)        PRDATA = {27'd0, err_q, x_full, a_full, done, busy};
            else if (sel_res && res_hit) PRDATA = y_ext;
        end
    end
endmodule
